// File: rtl/fmc_adc_pattern_gen_pkg.sv
// Shared types and helpers for the FMC-ADC test-pattern generator.
package fmc_adc_pattern_pkg;

    typedef enum logic [1:0] {
        PAT_CONST = 2'b00,
        PAT_TRI   = 2'b01,
        PAT_SAW   = 2'b10,
        PAT_CNT   = 2'b11
    } t_pattern_mode;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } t_pattern_state;

    // Widest supported sample; narrower builds use the low bits of each field.
    localparam int unsigned c_CFG_WIDTH = 16;

    typedef struct packed {
        t_pattern_mode          mode;
        logic                   err;
        logic [c_CFG_WIDTH-1:0] step;
        logic [c_CFG_WIDTH-1:0] lim_lo;
        logic [c_CFG_WIDTH-1:0] lim_hi;
        logic [c_CFG_WIDTH-1:0] cval;
        logic [c_CFG_WIDTH-1:0] offset;
    } t_pattern_cfg;

    typedef struct packed {
        logic               down;
        logic signed [31:0] value;
    } t_init_val;

    // Start value of channel k; a start above the upper limit is pinned there
    // and the channel begins by counting down.
    function automatic t_init_val f_clamp_init(input int lo, input int hi,
                                               input int offset, input int unsigned k);
        t_init_val r;
        int        start;
        start = lo + int'(k) * offset;
        if (start > hi) begin
            r.down  = 1'b1;
            r.value = hi;
        end else begin
            r.down  = 1'b0;
            r.value = start;
        end
        return r;
    endfunction

endpackage

// File: rtl/fmc_adc_pattern_gen_if.sv
// Configuration, strobe and sample bus of the test-pattern generator.
interface fmc_adc_pattern_gen_if #(
    parameter int unsigned g_NB_CHANNELS  = 4,
    parameter int unsigned g_SAMPLE_WIDTH = 16
);
    logic                                    enable_i;
    logic [1:0]                              mode_i;
    logic [g_SAMPLE_WIDTH-1:0]               step_i;
    logic [g_SAMPLE_WIDTH-1:0]               lim_lo_i;
    logic [g_SAMPLE_WIDTH-1:0]               lim_hi_i;
    logic [g_SAMPLE_WIDTH-1:0]               const_i;
    logic [g_SAMPLE_WIDTH-1:0]               ch_offset_i;
    logic                                    sample_en_i;
    logic [g_NB_CHANNELS*g_SAMPLE_WIDTH-1:0] data_o;
    logic                                    valid_o;
    logic [g_NB_CHANNELS-1:0]                wrap_o;
    logic                                    cfg_err_o;

    modport master (
        output enable_i, mode_i, step_i, lim_lo_i, lim_hi_i, const_i, ch_offset_i, sample_en_i,
        input  data_o, valid_o, wrap_o, cfg_err_o
    );

    modport slave (
        input  enable_i, mode_i, step_i, lim_lo_i, lim_hi_i, const_i, ch_offset_i, sample_en_i,
        output data_o, valid_o, wrap_o, cfg_err_o
    );
endinterface

// File: rtl/fmc_adc_pattern_gen_chan.sv
// One pattern channel: sample value, triangle direction and wrap pulse.
module fmc_adc_pattern_chan
    import fmc_adc_pattern_pkg::*;
#(
    parameter int unsigned g_SAMPLE_WIDTH = 16,
    parameter int unsigned g_CHAN_INDEX   = 0
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      strobe,
    input  t_pattern_cfg              cfg,
    output logic [g_SAMPLE_WIDTH-1:0] value,
    output logic                      wrap
);
    localparam int unsigned W  = g_SAMPLE_WIDTH;
    localparam int unsigned XW = W + 2;

    logic signed [W-1:0]  lo_w, hi_w, cur_w;
    logic signed [XW-1:0] lo_x, hi_x, step_x, cur_x, sum_up, sum_dn;
    logic [W-1:0]         val_q, val_nxt;
    logic                 down_q, down_nxt, wrap_q, wrap_nxt;
    t_init_val            init_v;
    logic [31:0]          init_raw;
    logic                 cfg_unused;

    assign lo_w     = cfg.lim_lo[W-1:0];
    assign hi_w     = cfg.lim_hi[W-1:0];
    assign cur_w    = val_q;
    assign lo_x     = XW'(lo_w);
    assign hi_x     = XW'(hi_w);
    assign cur_x    = XW'(cur_w);
    assign step_x   = XW'(cfg.step[W-1:0]);
    // Two guard bits keep the sum exact so the limit compare sees the true value.
    assign sum_up   = cur_x + step_x;
    assign sum_dn   = cur_x - step_x;
    assign init_v   = f_clamp_init(int'(lo_w), int'(hi_w), int'(cfg.offset[W-1:0]), g_CHAN_INDEX);
    assign init_raw = init_v.value;
    assign cfg_unused = ^{cfg, init_raw};

    // Next value: initialise on load, advance by mode on each strobe.
    always_comb begin
        val_nxt  = val_q;
        down_nxt = down_q;
        wrap_nxt = 1'b0;
        if (load) begin
            down_nxt = 1'b0;
            case (cfg.mode)
                PAT_CONST: val_nxt = cfg.cval[W-1:0];
                PAT_CNT:   val_nxt = W'(g_CHAN_INDEX);
                default: begin
                    if (cfg.err) begin
                        val_nxt = lo_w;
                    end else begin
                        val_nxt  = init_raw[W-1:0];
                        down_nxt = init_v.down;
                    end
                end
            endcase
        end else if (strobe) begin
            if (cfg.err) begin
                val_nxt = lo_w;
            end else begin
                case (cfg.mode)
                    PAT_CONST: val_nxt = cfg.cval[W-1:0];
                    PAT_TRI: begin
                        if (!down_q) begin
                            if (sum_up >= hi_x) begin
                                val_nxt  = hi_w;
                                down_nxt = 1'b1;
                                wrap_nxt = 1'b1;
                            end else begin
                                val_nxt = sum_up[W-1:0];
                            end
                        end else begin
                            if (sum_dn <= lo_x) begin
                                val_nxt  = lo_w;
                                down_nxt = 1'b0;
                                wrap_nxt = 1'b1;
                            end else begin
                                val_nxt = sum_dn[W-1:0];
                            end
                        end
                    end
                    PAT_SAW: begin
                        if (sum_up > hi_x) begin
                            val_nxt  = lo_w;
                            wrap_nxt = 1'b1;
                        end else begin
                            val_nxt = sum_up[W-1:0];
                        end
                    end
                    default: begin
                        val_nxt  = val_q + W'(1);
                        wrap_nxt = &val_q;
                    end
                endcase
            end
        end
    end

    // Channel state register.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            val_q  <= '0;
            down_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            val_q  <= val_nxt;
            down_q <= down_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign value = val_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/fmc_adc_pattern_gen.sv
// Multi-channel ADC test-pattern source: run FSM, configuration latch, packing.
module fmc_adc_pattern_gen
    import fmc_adc_pattern_pkg::*;
#(
    parameter int unsigned g_NB_CHANNELS  = 4,
    parameter int unsigned g_SAMPLE_WIDTH = 16
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_n_i,
    fmc_adc_pattern_gen_if.slave bus
);
    localparam int unsigned W = g_SAMPLE_WIDTH;
    localparam int unsigned N = g_NB_CHANNELS;

    t_pattern_state      state_q, state_nxt;
    logic                enable_d, load, strobe, valid_q;
    t_pattern_cfg        cfg_in, cfg_q, cfg_use;
    logic signed [W-1:0] lo_s, hi_s;
    logic [N*W-1:0]      data_pack;
    logic [N-1:0]        wrap_pack;

    assign lo_s = bus.lim_lo_i;
    assign hi_s = bus.lim_hi_i;

    // Assemble the live configuration and its legality.
    always_comb begin
        cfg_in        = '0;
        cfg_in.mode   = t_pattern_mode'(bus.mode_i);
        cfg_in.step   = c_CFG_WIDTH'(bus.step_i);
        cfg_in.lim_lo = c_CFG_WIDTH'(bus.lim_lo_i);
        cfg_in.lim_hi = c_CFG_WIDTH'(bus.lim_hi_i);
        cfg_in.cval   = c_CFG_WIDTH'(bus.const_i);
        cfg_in.offset = c_CFG_WIDTH'(bus.ch_offset_i);
        cfg_in.err    = ((cfg_in.mode == PAT_TRI) || (cfg_in.mode == PAT_SAW)) &&
                        ((lo_s >= hi_s) || (bus.step_i == '0));
    end

    // Channels see the live inputs during LOAD, the latched copy otherwise.
    assign cfg_use = load ? cfg_in : cfg_q;

    // FSM state and enable edge-detect registers.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q  <= ST_IDLE;
            enable_d <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            enable_d <= bus.enable_i;
        end
    end

    // Next state plus load/strobe qualifiers.
    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        strobe    = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.enable_i && !enable_d) state_nxt = ST_LOAD;
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.enable_i) state_nxt = ST_IDLE;
                else               strobe    = bus.sample_en_i;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Configuration latch and sample-valid flag.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            cfg_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load) cfg_q <= cfg_in;
            valid_q <= strobe;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_chan
        fmc_adc_pattern_chan #(
            .g_SAMPLE_WIDTH(W),
            .g_CHAN_INDEX  (k)
        ) u_chan (
            .clk_sys(sys_clk_i),
            .rst_n  (sys_rst_n_i),
            .load   (load),
            .strobe (strobe),
            .cfg    (cfg_use),
            .value  (data_pack[k*W +: W]),
            .wrap   (wrap_pack[k])
        );
    end

    assign bus.data_o    = data_pack;
    assign bus.valid_o   = valid_q;
    assign bus.wrap_o    = wrap_pack;
    assign bus.cfg_err_o = cfg_q.err;

endmodule

// File: tb/tb_fmc_adc_pattern_gen.sv
// Directed self-checking bench for fmc_adc_pattern_gen (16-bit and 8-bit builds).
module tb_fmc_adc_pattern_gen;
    import fmc_adc_pattern_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    int          saw_exp [4][4] = '{'{30, 60, 90, 0}, '{40, 70, 100, 0},
                                    '{50, 80, 0, 30}, '{60, 90, 0, 30}};
    logic [3:0]  saw_wrap [4]   = '{4'b0000, 4'b0000, 4'b1100, 4'b0011};
    logic [63:0] five4  = {4{16'd5}};
    logic [63:0] const4 = {4{16'h8123}};

    always #5 clk = ~clk;

    fmc_adc_pattern_gen_if #(.g_NB_CHANNELS(4), .g_SAMPLE_WIDTH(16)) pg ();
    fmc_adc_pattern_gen_if #(.g_NB_CHANNELS(4), .g_SAMPLE_WIDTH(8))  pg8 ();

    fmc_adc_pattern_gen #(.g_NB_CHANNELS(4), .g_SAMPLE_WIDTH(16)) dut (
        .sys_clk_i  (clk),
        .sys_rst_n_i(rst_n),
        .bus        (pg)
    );

    fmc_adc_pattern_gen #(.g_NB_CHANNELS(4), .g_SAMPLE_WIDTH(8)) dut8 (
        .sys_clk_i  (clk),
        .sys_rst_n_i(rst_n),
        .bus        (pg8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] s16(input int v);
        return 16'(v);
    endfunction

    function automatic logic [15:0] ch16(input int unsigned k);
        return pg.data_o[k*16 +: 16];
    endfunction

    function automatic logic [7:0] ch8(input int unsigned k);
        return pg8.data_o[k*8 +: 8];
    endfunction

    // Triangle -400..400 step 8 after n strobes, written out piecewise.
    function automatic int tri_exp(input int n);
        if (n <= 100)      return -400 + 8 * n;
        else if (n <= 200) return 400 - 8 * (n - 100);
        else               return -400 + 8 * (n - 200);
    endfunction

    task automatic set_cfg(input logic [1:0] mode, input int step, input int lo, input int hi,
                           input int cval, input int off);
        pg.mode_i      = mode;
        pg.step_i      = 16'(step);
        pg.lim_lo_i    = 16'(lo);
        pg.lim_hi_i    = 16'(hi);
        pg.const_i     = 16'(cval);
        pg.ch_offset_i = 16'(off);
    endtask

    initial begin
        rst_n = 1'b0;
        pg.enable_i = 1'b0;  pg.sample_en_i = 1'b0;
        set_cfg(2'b00, 0, 0, 0, 0, 0);
        pg8.enable_i = 1'b0; pg8.sample_en_i = 1'b0; pg8.mode_i = 2'b00;
        pg8.step_i = '0; pg8.lim_lo_i = '0; pg8.lim_hi_i = '0; pg8.const_i = '0; pg8.ch_offset_i = '0;
        tick(); tick();
        chk("rst_data", pg.data_o, 64'd0);
        chk("rst_valid", pg.valid_o, 1'b0);
        chk("rst_wrap", pg.wrap_o, 4'd0);
        chk("rst_err", pg.cfg_err_o, 1'b0);
        chk("rst_data8", pg8.data_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Triangle, with a strobe parked in the LOAD cycle
        set_cfg(2'b01, 8, -400, 400, 0, 0);
        pg.enable_i = 1'b1;
        tick();
        pg.sample_en_i = 1'b1;
        tick();
        chk("load_strobe_valid", pg.valid_o, 1'b0);
        chk("tri_init_ch0", ch16(0), s16(-400));
        chk("tri_init_ch3", ch16(3), s16(-400));
        for (int unsigned n = 1; n <= 250; n++) begin
            tick();
            chk($sformatf("tri_valid[%0d]", n), pg.valid_o, 1'b1);
            chk($sformatf("tri_ch0[%0d]", n), ch16(0), s16(tri_exp(int'(n))));
            chk($sformatf("tri_ch3[%0d]", n), ch16(3), s16(tri_exp(int'(n))));
            chk($sformatf("tri_wrap[%0d]", n), pg.wrap_o, ((n == 100) || (n == 200)) ? 4'hF : 4'h0);
        end
        pg.sample_en_i = 1'b0;
        tick();
        chk("gap_valid", pg.valid_o, 1'b0);
        chk("gap_hold", ch16(0), s16(0));

        // Step change during RUN is ignored; valid only in the cycle after the strobe
        pg.step_i = 16'd100;
        pg.sample_en_i = 1'b1;
        #1;
        chk("valid_not_same_cycle", pg.valid_o, 1'b0);
        tick();
        chk("step_ignored", ch16(0), s16(8));
        chk("valid_next_cycle", pg.valid_o, 1'b1);
        pg.sample_en_i = 1'b0;
        tick();
        chk("valid_one_cycle", pg.valid_o, 1'b0);

        // Enable drop coincident with a strobe, then a strobe in IDLE
        pg.enable_i = 1'b0;
        pg.sample_en_i = 1'b1;
        tick();
        chk("drop_strobe_valid", pg.valid_o, 1'b0);
        chk("drop_hold", ch16(0), s16(8));
        tick();
        chk("idle_strobe_valid", pg.valid_o, 1'b0);
        pg.sample_en_i = 1'b0;

        // Sawtooth with channel offset
        set_cfg(2'b10, 30, 0, 100, 0, 10);
        pg.enable_i = 1'b1;
        tick(); tick();
        chk("saw_err", pg.cfg_err_o, 1'b0);
        for (int unsigned k = 0; k < 4; k++)
            chk($sformatf("saw_init_ch%0d", k), ch16(k), s16(int'(10 * k)));
        pg.sample_en_i = 1'b1;
        for (int unsigned s = 0; s < 4; s++) begin
            tick();
            for (int unsigned k = 0; k < 4; k++)
                chk($sformatf("saw_ch%0d[%0d]", k, s), ch16(k), s16(saw_exp[k][s]));
            chk($sformatf("saw_wrap[%0d]", s), pg.wrap_o, saw_wrap[s]);
        end
        pg.sample_en_i = 1'b0;
        pg.enable_i = 1'b0;
        tick();

        // Illegal triangle lo == hi
        set_cfg(2'b01, 8, 5, 5, 0, 0);
        pg.enable_i = 1'b1;
        tick();
        chk("err_not_in_load", pg.cfg_err_o, 1'b0);
        tick();
        chk("err_set", pg.cfg_err_o, 1'b1);
        chk("err_init_data", pg.data_o, five4);
        pg.sample_en_i = 1'b1;
        for (int unsigned s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("err_data[%0d]", s), pg.data_o, five4);
            chk($sformatf("err_wrap[%0d]", s), pg.wrap_o, 4'd0);
            chk($sformatf("err_valid[%0d]", s), pg.valid_o, 1'b1);
        end
        pg.sample_en_i = 1'b0;
        pg.enable_i = 1'b0;
        tick();
        chk("err_held_idle", pg.cfg_err_o, 1'b1);

        // Illegal sawtooth step 0
        set_cfg(2'b10, 0, 0, 100, 0, 0);
        pg.enable_i = 1'b1;
        tick(); tick();
        chk("err_step0", pg.cfg_err_o, 1'b1);
        pg.enable_i = 1'b0;
        tick();

        // Legal triangle clears the error; channel 3 starts clamped and heading down
        set_cfg(2'b01, 8, -400, 400, 0, 300);
        pg.enable_i = 1'b1;
        tick(); tick();
        chk("err_cleared", pg.cfg_err_o, 1'b0);
        chk("clamp_init_ch0", ch16(0), s16(-400));
        chk("clamp_init_ch1", ch16(1), s16(-100));
        chk("clamp_init_ch2", ch16(2), s16(200));
        chk("clamp_init_ch3", ch16(3), s16(400));
        pg.sample_en_i = 1'b1;
        tick();
        pg.sample_en_i = 1'b0;
        chk("clamp_ch0", ch16(0), s16(-392));
        chk("clamp_ch2", ch16(2), s16(208));
        chk("clamp_ch3_down", ch16(3), s16(392));
        chk("clamp_wrap", pg.wrap_o, 4'd0);

        // Reset mid-RUN
        rst_n = 1'b0;
        pg.enable_i = 1'b0;
        tick();
        chk("midrst_data", pg.data_o, 64'd0);
        chk("midrst_valid", pg.valid_o, 1'b0);
        chk("midrst_err", pg.cfg_err_o, 1'b0);
        rst_n = 1'b1;
        pg.sample_en_i = 1'b1;
        tick();
        chk("midrst_idle_valid", pg.valid_o, 1'b0);
        chk("midrst_idle_data", pg.data_o, 64'd0);
        pg.sample_en_i = 1'b0;

        // Constant mode: step 0 is legal here
        set_cfg(2'b00, 0, 0, 0, 16'h8123, 0);
        pg.enable_i = 1'b1;
        tick(); tick();
        chk("const_err", pg.cfg_err_o, 1'b0);
        chk("const_init", pg.data_o, const4);
        pg.sample_en_i = 1'b1;
        tick();
        chk("const_data", pg.data_o, const4);
        chk("const_wrap", pg.wrap_o, 4'd0);
        chk("const_valid", pg.valid_o, 1'b1);
        pg.sample_en_i = 1'b0;
        pg.enable_i = 1'b0;
        tick();

        // Counter mode on the 8-bit build
        pg8.mode_i = 2'b11;
        pg8.enable_i = 1'b1;
        tick(); tick();
        chk("cnt_err", pg8.cfg_err_o, 1'b0);
        chk("cnt_init_ch0", ch8(0), 8'd0);
        chk("cnt_init_ch3", ch8(3), 8'd3);
        pg8.sample_en_i = 1'b1;
        for (int unsigned n = 1; n <= 260; n++) begin
            tick();
            chk($sformatf("cnt_ch3[%0d]", n), ch8(3), 8'((3 + n) % 256));
            chk($sformatf("cnt_wrap3[%0d]", n), pg8.wrap_o[3], (n == 253));
            chk($sformatf("cnt_wrap0[%0d]", n), pg8.wrap_o[0], (n == 256));
        end
        pg8.sample_en_i = 1'b0;
        pg8.enable_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
